// File: rtl/cpu_pkg.sv
// Shared CPU definitions: major opcodes and the memory-stage state encoding.
// Imported by the decode, execute and memory stages.
package cpu_pkg;

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BR   = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts WAIT cycles without an acknowledge and flags the cycle on which the
// outstanding memory access must be abandoned.
module mem_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout_hit
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Holding at LAST keeps the counter from ever wrapping.
    assign timeout_hit = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !timeout_hit) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues lw/sw over a req/ack port with a watchdog and
// forwards every completing instruction's result to writeback.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bubble,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [2:0]        in_dest,
    input  logic              flush,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [2:0]        wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    mem_state_e        state, state_next;
    logic              in_wait, timeout_hit, accept, acc_mem, acc_wb, done, mem_wb;
    logic [DATA_W-1:0] mem_wb_data;
    logic              is_lw_q;
    logic [2:0]        dest_q;
    logic              pend_valid;
    logic [2:0]        pend_dest;
    logic [DATA_W-1:0] pend_data;

    // Handshake: an instruction moves in on any cycle where it is valid, not a
    // bubble, not flushed and stall is low; stall only holds while an access is
    // outstanding and neither ack nor timeout ends it this cycle.
    assign in_wait     = (state == ST_WAIT);
    assign stall       = in_wait & ~mem_ack & ~timeout_hit;
    assign accept      = in_valid & ~in_bubble & ~flush & ~stall;
    assign acc_mem     = accept & is_mem_op(in_op);
    assign acc_wb      = accept & ~is_mem_op(in_op) & (in_op != OP_BR) & (in_dest != 3'd0);
    assign done        = in_wait & (mem_ack | timeout_hit);
    assign mem_wb      = done & is_lw_q & (dest_q != 3'd0);
    assign mem_wb_data = mem_ack ? mem_rdata : '0;

    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (acc_mem),
        .enable      (in_wait & ~mem_ack),
        .timeout_hit (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (acc_mem) state_next = ST_WAIT;
            ST_WAIT: if (done) state_next = acc_mem ? ST_WAIT : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_err    <= 1'b0;
            is_lw_q    <= 1'b0;
            dest_q     <= 3'd0;
            wb_valid   <= 1'b0;
            wb_dest    <= 3'd0;
            wb_data    <= '0;
            pend_valid <= 1'b0;
            pend_dest  <= 3'd0;
            pend_data  <= '0;
        end else begin
            mem_err <= timeout_hit;
            if (acc_mem) begin
                mem_req   <= 1'b1;
                mem_we    <= (in_op == OP_SW);
                mem_addr  <= in_result;
                mem_wdata <= in_store_data;
                is_lw_q   <= (in_op == OP_LW);
                dest_q    <= in_dest;
            end else if (done) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end

            // A load completing alongside a newly accepted ALU result would need
            // two writebacks in one cycle; the ALU result waits one cycle in pend.
            if (mem_wb) begin
                wb_valid <= 1'b1;
                wb_dest  <= dest_q;
                wb_data  <= mem_wb_data;
            end else if (pend_valid) begin
                wb_valid <= 1'b1;
                wb_dest  <= pend_dest;
                wb_data  <= pend_data;
            end else if (acc_wb) begin
                wb_valid <= 1'b1;
                wb_dest  <= in_dest;
                wb_data  <= in_result;
            end else begin
                wb_valid <= 1'b0;
            end
            pend_valid <= acc_wb & (mem_wb | pend_valid);
            if (acc_wb) begin
                pend_dest <= in_dest;
                pend_data <= in_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage: a driver issues instructions, a
// memory responder acks per plan, and a monitor checks writebacks in order.
module tb_mem_stage;

    localparam int W  = 16;
    localparam int TO = 4;

    localparam logic [2:0] OP_ALU = 3'b000;
    localparam logic [2:0] OP_SW  = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;
    localparam logic [2:0] OP_BR  = 3'b110;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_bubble, flush, mem_ack;
    logic [2:0]   in_op, in_dest;
    logic [W-1:0] in_result, in_store_data, mem_rdata;
    logic         stall, mem_req, mem_we, wb_valid, mem_err;
    logic [W-1:0] mem_addr, mem_wdata, wb_data;
    logic [2:0]   wb_dest;

    typedef struct {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] rdata;
        int           d;
    } plan_t;

    plan_t          plan_q[$];
    logic [W+2:0]   exp_q[$];
    int             vectors = 0;
    int             errors = 0;
    int             exp_err = 0;
    int             err_seen = 0;
    bit             resp_en = 1'b1;

    mem_stage #(.DATA_W(W), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bubble(in_bubble),
        .in_op(in_op), .in_result(in_result), .in_store_data(in_store_data),
        .in_dest(in_dest), .flush(flush), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
        .wb_dest(wb_dest), .wb_data(wb_data), .mem_err(mem_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: event not expected", name);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [2:0] op, input logic [W-1:0] res, input logic [W-1:0] sd,
                         input logic [2:0] dest, input logic bub, input logic fl,
                         input int d, input logic [W-1:0] rd, output int stalls);
        plan_t p;
        stalls = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_result = res; in_store_data = sd;
        in_dest = dest; in_bubble = bub; flush = fl;
        #2;
        while (!bub && !fl && stall === 1'b1) begin
            stalls++;
            if (stalls > 100) begin
                fail("accept_timeout");
                break;
            end
            @(negedge clk);
            #2;
        end
        if (!bub && !fl && stall === 1'b0) begin
            if (op == OP_SW || op == OP_LW) begin
                p.we = (op == OP_SW); p.addr = res; p.wdata = sd; p.rdata = rd; p.d = d;
                plan_q.push_back(p);
                if (d >= TO) exp_err++;
                if (op == OP_LW && dest != 3'd0)
                    exp_q.push_back({dest, (d >= TO) ? {W{1'b0}} : rd});
            end else if (op != OP_BR && dest != 3'd0) begin
                exp_q.push_back({dest, res});
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_bubble = 1'b0; flush = 1'b0;
    endtask

    // ---------------- memory responder ----------------
    initial begin
        bit    have_edge;
        plan_t p;
        int    waited;
        have_edge = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            if (!have_edge) @(negedge clk);
            have_edge = 1'b0;
            if (resp_en && rst_n === 1'b1 && mem_req === 1'b1) begin
                if (plan_q.size() == 0) begin
                    fail("unexpected_req");
                end else begin
                    p = plan_q.pop_front();
                    check("req_we", mem_we, p.we);
                    check("req_addr", mem_addr, p.addr);
                    check("req_wdata", mem_wdata, p.wdata);
                    waited = 0;
                    forever begin
                        if (waited == p.d) begin
                            mem_ack = 1'b1;
                            mem_rdata = p.rdata;
                            #1;
                            check("stall_on_ack", stall, 1'b0);
                            @(negedge clk);
                            mem_ack = 1'b0;
                            mem_rdata = W'($urandom);
                            check("err_after_ack", mem_err, 1'b0);
                            have_edge = 1'b1;
                            break;
                        end
                        #1;
                        check("stall_wait", stall, logic'(waited != TO - 1));
                        @(negedge clk);
                        waited++;
                        if (waited == TO) begin
                            check("err_after_timeout", mem_err, 1'b1);
                            have_edge = 1'b1;
                            break;
                        end
                        check("req_held", mem_req, 1'b1);
                        check("addr_held", mem_addr, p.addr);
                        check("we_held", mem_we, p.we);
                        check("wdata_held", mem_wdata, p.wdata);
                    end
                end
            end
        end
    end

    // ---------------- writeback monitor / scoreboard ----------------
    initial begin
        logic [W+2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (mem_err === 1'b1) err_seen++;
                if (wb_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        fail("wb_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_dest", wb_dest, e[W+2:W]);
                        check("wb_data", wb_data, e[W-1:0]);
                    end
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || plan_q.size() != 0); i++) @(negedge clk);
        repeat (TO + 4) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int st;
        int sel, dd;
        logic [2:0] op;
        in_valid = 1'b0; in_bubble = 1'b0; flush = 1'b0; in_op = 3'd0;
        in_result = '0; in_store_data = '0; in_dest = 3'd0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_wb_data", wb_data, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ALU op: one-cycle writeback, no stall
        drive(OP_ALU, 16'h1234, 16'h0, 3'd3, 1'b0, 1'b0, 0, 16'h0, st);
        check("alu_stalls", st, 0);
        check("alu_wb_valid", wb_valid, 1'b1);
        check("alu_wb_data", wb_data, 16'h1234);
        check("alu_wb_dest", wb_dest, 3'd3);

        // lw acked on the third WAIT cycle
        drive(OP_LW, 16'h0040, 16'h0, 3'd5, 1'b0, 1'b0, 2, 16'hBEEF, st);
        drain();

        // sw acked immediately, lw accepted on the ack cycle
        drive(OP_SW, 16'h0100, 16'h00AA, 3'd2, 1'b0, 1'b0, 0, 16'h7777, st);
        drive(OP_LW, 16'h0101, 16'h0, 3'd6, 1'b0, 1'b0, 0, 16'h1111, st);
        check("b2b_stalls", st, 0);
        drain();

        // lw never acked: timeout, zero writeback; then ack exactly on the last cycle
        drive(OP_LW, 16'h0300, 16'h0, 3'd7, 1'b0, 1'b0, TO + 3, 16'h5555, st);
        drive(OP_LW, 16'h0302, 16'h0, 3'd1, 1'b0, 1'b0, TO - 1, 16'h6666, st);
        drain();

        // flushed lw, ALU to r0, branch: nothing must come out
        drive(OP_LW, 16'h0400, 16'h0, 3'd4, 1'b0, 1'b1, 0, 16'h0, st);
        drive(OP_ALU, 16'h0404, 16'h0, 3'd0, 1'b0, 1'b0, 0, 16'h0, st);
        drive(OP_BR, 16'h0408, 16'h0, 3'd4, 1'b0, 1'b0, 0, 16'h0, st);
        drain();

        // randomised traffic
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                6:       dd = TO - 1;
                7:       dd = TO;
                8:       dd = TO + 2;
                default: dd = $urandom_range(0, 2);
            endcase
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 0) ? OP_LW : OP_SW;
            drive(op, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                  logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 9) == 0),
                  dd, W'($urandom), st);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        // async reset while an sw waits for its ack
        resp_en = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_SW; in_result = 16'h0200; in_store_data = 16'h0055; in_dest = 3'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("rst_test_req_up", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req_clear", mem_req, 1'b0);
        check("async_we_clear", mem_we, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_stall", stall, 1'b0);
        for (int i = 0; i < 2 * TO; i++) begin
            @(negedge clk);
            check("post_rst_req", mem_req, 1'b0);
            check("post_rst_wb", wb_valid, 1'b0);
        end

        check("exp_q_left", exp_q.size(), 0);
        check("plan_q_left", plan_q.size(), 0);
        check("mem_err_count", err_seen, exp_err);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
